// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Brief    : MIPS memory-access stage; load data extraction, LWL/LWR merge,
//            write-back handshake and read-data hold buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 105,
  parameter int MS_TO_WS_BUS_WD = 70
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_fwd_we,
  output logic [4:0]                 ms_fwd_dest,
  output logic [31:0]                ms_fwd_data
);

  typedef enum logic [0:0] {
    BUF_EMPTY = 1'b0,
    BUF_HELD  = 1'b1
  } buf_state_t;

  logic                       r_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] r_es_bus;
  buf_state_t                 r_buf_state;
  logic [31:0]                r_buf_data;

  logic        w_ms_ready_go;
  logic [2:0]  w_ld_op;
  logic [31:0] w_rt_value;
  logic        w_gr_we;
  logic [4:0]  w_dest;
  logic [31:0] w_alu_result;
  logic [31:0] w_pc;
  logic [1:0]  w_addr;
  logic [31:0] w_rd;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_final_result;

  assign {w_ld_op, w_rt_value, w_gr_we, w_dest, w_alu_result, w_pc} = r_es_bus;
  assign w_addr = w_alu_result[1:0];

  assign w_ms_ready_go  = 1'b1;
  assign ms_allowin     = !r_ms_valid | (w_ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = r_ms_valid & w_ms_ready_go;

  // SRAM data is only valid in the instruction's first cycle; afterwards the buffer stands in.
  assign w_rd   = (r_buf_state == BUF_HELD) ? r_buf_data : data_sram_rdata;
  assign w_byte = w_rd[{w_addr, 3'b000} +: 8];
  assign w_half = w_addr[1] ? w_rd[31:16] : w_rd[15:0];

  always_comb begin
    w_final_result = w_alu_result;
    case (w_ld_op)
      3'd1: w_final_result = {{24{w_byte[7]}}, w_byte};
      3'd2: w_final_result = {24'd0, w_byte};
      3'd3: w_final_result = {{16{w_half[15]}}, w_half};
      3'd4: w_final_result = {16'd0, w_half};
      3'd5: w_final_result = w_rd;
      3'd6: begin
        case (w_addr)
          2'd0:    w_final_result = {w_rd[7:0],  w_rt_value[23:0]};
          2'd1:    w_final_result = {w_rd[15:0], w_rt_value[15:0]};
          2'd2:    w_final_result = {w_rd[23:0], w_rt_value[7:0]};
          default: w_final_result = w_rd;
        endcase
      end
      3'd7: begin
        case (w_addr)
          2'd0:    w_final_result = w_rd;
          2'd1:    w_final_result = {w_rt_value[31:24], w_rd[31:8]};
          2'd2:    w_final_result = {w_rt_value[31:16], w_rd[31:16]};
          default: w_final_result = {w_rt_value[31:8],  w_rd[31:24]};
        endcase
      end
      default: w_final_result = w_alu_result;
    endcase
  end

  assign ms_to_ws_bus = {w_gr_we, w_dest, w_final_result, w_pc};
  assign ms_fwd_we    = r_ms_valid & w_gr_we;
  assign ms_fwd_dest  = w_dest;
  assign ms_fwd_data  = w_final_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ms_valid  <= 1'b0;
      r_es_bus    <= '0;
      r_buf_state <= BUF_EMPTY;
      r_buf_data  <= 32'd0;
    end else begin
      if (ms_allowin) begin
        r_ms_valid <= es_to_ms_valid;
      end
      if (es_to_ms_valid && ms_allowin) begin
        r_es_bus <= es_to_ms_bus;
      end
      case (r_buf_state)
        BUF_EMPTY: begin
          if (r_ms_valid && !ws_allowin) begin
            r_buf_data  <= data_sram_rdata;
            r_buf_state <= BUF_HELD;
          end
        end
        default: begin
          if (ms_to_ws_valid && ws_allowin) begin
            r_buf_state <= BUF_EMPTY;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Self-checking bench for mem_stage; directed cases plus random
//            traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [104:0] es_to_ms_bus;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [69:0]  ms_to_ws_bus;
  logic [31:0]  data_sram_rdata;
  logic         ms_fwd_we;
  logic [4:0]   ms_fwd_dest;
  logic [31:0]  ms_fwd_data;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the instruction in the stage and the data it loaded.
  bit           m_known = 0;
  bit           m_valid = 0;
  bit           m_fresh = 0;
  logic [104:0] m_bus   = '0;
  logic [31:0]  m_rd    = '0;

  logic [69:0]  obs_bus;
  logic         obs_valid;
  logic         obs_allowin;
  logic         obs_fwd_we;

  mem_stage #(.ES_TO_MS_BUS_WD(105), .MS_TO_WS_BUS_WD(70)) dut (
    .clk             (clk),
    .reset           (reset),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .ws_allowin      (ws_allowin),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .data_sram_rdata (data_sram_rdata),
    .ms_fwd_we       (ms_fwd_we),
    .ms_fwd_dest     (ms_fwd_dest),
    .ms_fwd_data     (ms_fwd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [104:0] mk_bus(input int ld, input logic [31:0] rt, input bit we,
                                          input int dest, input logic [31:0] alu, input logic [31:0] pc);
    logic [104:0] b;
    b = {3'(ld), rt, we, 5'(dest), alu, pc};
    return b;
  endfunction

  // Load semantics written as shifts and masks over the word.
  function automatic logic [31:0] ref_result(input logic [2:0] ld, input logic [31:0] rt,
                                             input logic [31:0] alu, input logic [31:0] rd);
    int          sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [63:0] t;
    sh = 8 * int'(alu[1:0]);
    b  = 8'(rd >> sh);
    h  = 16'(rd >> ((alu[1:0] >= 2) ? 16 : 0));
    case (ld)
      3'd1: return 32'($signed(b));
      3'd2: return 32'(b);
      3'd3: return 32'($signed(h));
      3'd4: return 32'(h);
      3'd5: return rd;
      3'd6: begin
        t = ({32'd0, rd} << (24 - sh)) | ({32'd0, rt} & ((64'd1 << (24 - sh)) - 64'd1));
        return t[31:0];
      end
      3'd7: return (rd >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
      default: return alu;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic cycle(input bit v, input logic [104:0] bus, input logic [31:0] rdata,
                       input bit ws, input bit rst);
    logic [31:0] rd;
    logic [31:0] exp_res;
    es_to_ms_valid  = v;
    es_to_ms_bus    = bus;
    data_sram_rdata = rdata;
    ws_allowin      = ws;
    reset           = rst;
    #1;
    obs_bus     = ms_to_ws_bus;
    obs_valid   = ms_to_ws_valid;
    obs_allowin = ms_allowin;
    obs_fwd_we  = ms_fwd_we;
    if (m_known) begin
      chk("to_ws_valid", 70'(ms_to_ws_valid), 70'(m_valid));
      chk("allowin", 70'(ms_allowin), 70'(!m_valid || ws));
      chk("fwd_we", 70'(ms_fwd_we), 70'(m_valid && m_bus[69]));
      if (m_valid) begin
        rd      = m_fresh ? rdata : m_rd;
        exp_res = ref_result(m_bus[104:102], m_bus[101:70], m_bus[63:32], rd);
        chk("to_ws_bus", ms_to_ws_bus, {m_bus[69:64], exp_res, m_bus[31:0]});
        chk("fwd_dest_data", {33'd0, ms_fwd_dest, ms_fwd_data}, {33'd0, m_bus[68:64], exp_res});
      end
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 0;
      m_fresh = 0;
      m_known = 1;
    end else begin
      if (m_valid && !ws && m_fresh) begin
        m_rd    = rdata;
        m_fresh = 0;
      end
      if (!m_valid || ws) begin
        m_valid = v;
        if (v) begin
          m_bus   = bus;
          m_fresh = 1;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] pc;
    bit          v;
    bit          ws;
    bit          rst;
    int          ld;

    // Reset and reset state
    cycle(0, '0, 32'h5A5A_5A5A, 1, 1);
    cycle(0, '0, 32'h5A5A_5A5A, 1, 1);
    cycle(0, '0, 32'h1357_9BDF, 1, 0);
    chk("reset_bus", obs_bus, 70'd0);
    chk("reset_allowin", 70'(obs_allowin), 70'd1);
    chk("reset_valid", 70'(obs_valid), 70'd0);

    // LW
    cycle(1, mk_bus(5, 32'h0, 1, 8, 32'h1000, 32'hBFC0_0000), 32'h0, 1, 0);
    cycle(0, '0, 32'hDEAD_BEEF, 1, 0);
    chk("lw_result", 70'(obs_bus[63:32]), 70'(32'hDEAD_BEEF));
    chk("lw_dest", 70'(obs_bus[68:64]), 70'd8);
    chk("lw_fwd_we", 70'(obs_fwd_we), 70'd1);

    // Byte / half loads
    cycle(1, mk_bus(1, 32'h0, 1, 1, 32'h2003, 32'h10), 32'h0, 1, 0);
    cycle(1, mk_bus(2, 32'h0, 1, 2, 32'h2003, 32'h14), 32'h80FF_1234, 1, 0);
    chk("lb_a3", 70'(obs_bus[63:32]), 70'(32'hFFFF_FF80));
    cycle(1, mk_bus(3, 32'h0, 1, 3, 32'h2002, 32'h18), 32'h80FF_1234, 1, 0);
    chk("lbu_a3", 70'(obs_bus[63:32]), 70'(32'h0000_0080));
    cycle(1, mk_bus(4, 32'h0, 1, 4, 32'h2002, 32'h1C), 32'h80FF_1234, 1, 0);
    chk("lh_a2", 70'(obs_bus[63:32]), 70'(32'hFFFF_80FF));
    cycle(1, mk_bus(6, 32'hAABB_CCDD, 1, 5, 32'h3001, 32'h20), 32'h80FF_1234, 1, 0);
    chk("lhu_a2", 70'(obs_bus[63:32]), 70'(32'h0000_80FF));

    // LWL / LWR, back-to-back by pc
    cycle(1, mk_bus(7, 32'hAABB_CCDD, 1, 6, 32'h3001, 32'h24), 32'h1122_3344, 1, 0);
    chk("lwl_a1", 70'(obs_bus[63:32]), 70'(32'h3344_CCDD));
    chk("lwl_pc", 70'(obs_bus[31:0]), 70'(32'h20));
    cycle(1, mk_bus(6, 32'hAABB_CCDD, 1, 7, 32'h3003, 32'h28), 32'h1122_3344, 1, 0);
    chk("lwr_a1", 70'(obs_bus[63:32]), 70'(32'hAA11_2233));
    chk("lwr_pc", 70'(obs_bus[31:0]), 70'(32'h24));
    cycle(1, mk_bus(7, 32'hAABB_CCDD, 1, 9, 32'h3000, 32'h2C), 32'h1122_3344, 1, 0);
    chk("lwl_a3", 70'(obs_bus[63:32]), 70'(32'h1122_3344));
    cycle(0, '0, 32'h1122_3344, 1, 0);
    chk("lwr_a0", 70'(obs_bus[63:32]), 70'(32'h1122_3344));
    chk("lwr_a0_valid", 70'(obs_valid), 70'd1);
    cycle(0, '0, 32'h0, 1, 0);
    chk("bubble_valid", 70'(obs_valid), 70'd0);

    // Stall with changing SRAM data
    cycle(1, mk_bus(5, 32'h0, 1, 10, 32'h4000, 32'h40), 32'h0, 1, 0);
    cycle(0, '0, 32'h1234_5678, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, '0, 32'h0, 0, 0);
      chk("stall_result", 70'(obs_bus[63:32]), 70'(32'h1234_5678));
      chk("stall_allowin", 70'(obs_allowin), 70'd0);
    end
    cycle(0, '0, 32'h0, 1, 0);
    chk("stall_leave", 70'(obs_bus[63:32]), 70'(32'h1234_5678));
    cycle(0, '0, 32'h0, 1, 0);
    chk("stall_after", 70'(obs_valid), 70'd0);

    // Reset during a held stall
    cycle(1, mk_bus(5, 32'h0, 1, 11, 32'h5000, 32'h50), 32'h0, 1, 0);
    cycle(1, mk_bus(5, 32'h0, 1, 12, 32'h5004, 32'h54), 32'hCAFE_F00D, 0, 0);
    cycle(1, mk_bus(5, 32'h0, 1, 12, 32'h5004, 32'h54), 32'h0, 0, 1);
    cycle(0, '0, 32'h0, 0, 0);
    chk("rst_hold_valid", 70'(obs_valid), 70'd0);
    chk("rst_hold_allowin", 70'(obs_allowin), 70'd1);
    chk("rst_hold_fwd_we", 70'(obs_fwd_we), 70'd0);

    // Random traffic
    pc = 32'h8000_0000;
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      ws  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 59) == 0);
      ld  = $urandom_range(0, 7);
      cycle(v, mk_bus(ld, $urandom, 1'($urandom), $urandom_range(0, 31), $urandom, pc),
            $urandom, ws, rst);
      pc = pc + 32'd4;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
